// File: rtl/seq_pkg.sv
// Shared constants for the step sequencer: direction codes, minimum tone
// half-period and the 16-entry note table (50 MHz half-periods, 250 Hz..1 kHz).
package seq_pkg;

    typedef enum logic [1:0] {
        DIR_FWD  = 2'd0,
        DIR_REV  = 2'd1,
        DIR_PP   = 2'd2,
        DIR_FWD3 = 2'd3
    } dir_mode_t;

    localparam int unsigned HALF_MIN = 1;

    // Half-period = 25e6 / f, with f stepping by 50 Hz from 250 Hz to 1 kHz
    function automatic logic [19:0] tone_half(input logic [3:0] note);
        logic [19:0] half;
        case (note)
            4'd0:    half = 20'd100000;
            4'd1:    half = 20'd83333;
            4'd2:    half = 20'd71428;
            4'd3:    half = 20'd62500;
            4'd4:    half = 20'd55555;
            4'd5:    half = 20'd50000;
            4'd6:    half = 20'd45454;
            4'd7:    half = 20'd41666;
            4'd8:    half = 20'd38461;
            4'd9:    half = 20'd35714;
            4'd10:   half = 20'd33333;
            4'd11:   half = 20'd31250;
            4'd12:   half = 20'd29411;
            4'd13:   half = 20'd27777;
            4'd14:   half = 20'd26315;
            4'd15:   half = 20'd25000;
            default: half = 20'd25000;
        endcase
        return half;
    endfunction

endpackage

// File: rtl/step_sequencer_engine_if.sv
// Control/status bundle between the sequencer engine and its host.
interface step_sequencer_engine_if #(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = $clog2(NUM_STEPS),
    parameter int NOTE_W    = 4,
    parameter int TEMPO_W   = 28
);
    logic                 run;
    logic [1:0]           dir_mode;
    logic [TEMPO_W-1:0]   tempo_period;
    logic [TEMPO_W-1:0]   gate_period;
    logic [NUM_STEPS-1:0] step_mask;
    logic                 cfg_we;
    logic [STEP_W-1:0]    cfg_addr;
    logic [NOTE_W-1:0]    cfg_note;
    logic                 snd_out;
    logic [NUM_STEPS-1:0] step_led;
    logic [STEP_W-1:0]    step_idx;
    logic                 step_tick;

    modport master (
        output run, dir_mode, tempo_period, gate_period, step_mask,
               cfg_we, cfg_addr, cfg_note,
        input  snd_out, step_led, step_idx, step_tick
    );

    modport slave (
        input  run, dir_mode, tempo_period, gate_period, step_mask,
               cfg_we, cfg_addr, cfg_note,
        output snd_out, step_led, step_idx, step_tick
    );
endinterface

// File: rtl/seq_tone_gen.sv
// Loadable half-period divider: restart loads a new half-period and starts
// the square wave high; otherwise it toggles every i_half enabled cycles.
module seq_tone_gen #(
    parameter int TONE_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_restart,
    input  logic [TONE_W-1:0] i_half,
    output logic              o_sq
);
    logic [TONE_W-1:0] r_half;
    logic [TONE_W-1:0] r_cnt;
    logic              r_sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half <= {TONE_W{1'b0}};
            r_cnt  <= {TONE_W{1'b0}};
            r_sq   <= 1'b0;
        end else if (i_restart) begin
            r_half <= i_half;
            r_cnt  <= {TONE_W{1'b0}};
            r_sq   <= 1'b1;
        end else if (i_en) begin
            if (r_cnt >= r_half - TONE_W'(1)) begin
                r_cnt <= {TONE_W{1'b0}};
                r_sq  <= ~r_sq;
            end else begin
                r_cnt <= r_cnt + TONE_W'(1);
            end
        end
    end

    assign o_sq = r_sq;
endmodule

// File: rtl/step_sequencer_engine.sv
// N-step audio step sequencer: tempo-timed step pointer, per-step note RAM,
// gated square-wave output. Ping-pong playback is built only with SEQ_PINGPONG_EN.
module step_sequencer_engine
    import seq_pkg::*;
#(
    parameter int NUM_STEPS  = 8,
    parameter int STEP_W     = $clog2(NUM_STEPS),
    parameter int NOTE_W     = 4,
    parameter int TONE_W     = 20,
    parameter int TEMPO_W    = 28,
    parameter int TONE_SHIFT = 0
) (
    input logic                    clk,
    input logic                    rst,
    step_sequencer_engine_if.slave bus
);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    logic [TEMPO_W-1:0]   r_tempo_cnt;
    logic [TEMPO_W-1:0]   r_gate_cnt;
    logic [STEP_W-1:0]    r_step;
    logic [NUM_STEPS-1:0] r_led;
    logic                 r_tick;
    logic                 r_run_d;
    logic                 r_snd;
    logic [NOTE_W-1:0]    r_note_ram [NUM_STEPS];

    logic                 w_adv;
    logic                 w_enter;
    logic                 w_tone_sq;
    logic                 w_gate_open;
    logic [STEP_W-1:0]    w_next_step;
    logic [STEP_W-1:0]    w_entry_step;
    logic [TONE_W-1:0]    w_half_raw;
    logic [TONE_W-1:0]    w_half;
`ifdef SEQ_PINGPONG_EN
    logic                 r_dir_down;
    logic                 w_dir_down_nxt;
`endif

    // Entry happens on every advance and on the first cycle after a pause
    assign w_adv        = bus.run && (r_tempo_cnt >= bus.tempo_period);
    assign w_enter      = bus.run && (w_adv || !r_run_d);
    assign w_entry_step = w_adv ? w_next_step : r_step;
    assign w_half_raw   = TONE_W'(tone_half(4'(r_note_ram[w_entry_step])) >> TONE_SHIFT);
    assign w_half       = (w_half_raw < TONE_W'(HALF_MIN)) ? TONE_W'(HALF_MIN) : w_half_raw;
    assign w_gate_open  = (r_gate_cnt < bus.gate_period) && bus.step_mask[r_step];

    always_comb begin
        w_next_step = (r_step == LAST_STEP) ? STEP_ZERO : r_step + STEP_W'(1);
`ifdef SEQ_PINGPONG_EN
        w_dir_down_nxt = r_dir_down;
`endif
        case (bus.dir_mode)
            DIR_REV: w_next_step = (r_step == STEP_ZERO) ? LAST_STEP : r_step - STEP_W'(1);
`ifdef SEQ_PINGPONG_EN
            DIR_PP: begin
                if (r_step == LAST_STEP) begin
                    w_dir_down_nxt = 1'b1;
                end else if (r_step == STEP_ZERO) begin
                    w_dir_down_nxt = 1'b0;
                end else begin
                    w_dir_down_nxt = r_dir_down;
                end
                w_next_step = w_dir_down_nxt ? r_step - STEP_W'(1) : r_step + STEP_W'(1);
            end
`endif
            default: w_next_step = (r_step == LAST_STEP) ? STEP_ZERO : r_step + STEP_W'(1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tempo_cnt <= {TEMPO_W{1'b0}};
            r_gate_cnt  <= {TEMPO_W{1'b0}};
            r_step      <= STEP_ZERO;
            r_led       <= NUM_STEPS'(1);
            r_tick      <= 1'b0;
            r_run_d     <= 1'b0;
            r_snd       <= 1'b0;
`ifdef SEQ_PINGPONG_EN
            r_dir_down  <= 1'b0;
`endif
        end else begin
            r_run_d <= bus.run;
            r_tick  <= w_adv;
            // The cycle that re-enters a step after a pause still sees stale tone state
            r_snd   <= bus.run && r_run_d && w_tone_sq && w_gate_open;
            if (!bus.run || w_adv) begin
                r_tempo_cnt <= {TEMPO_W{1'b0}};
            end else begin
                r_tempo_cnt <= r_tempo_cnt + TEMPO_W'(1);
            end
            if (w_adv) begin
                r_step <= w_next_step;
                r_led  <= NUM_STEPS'(1) << w_next_step;
`ifdef SEQ_PINGPONG_EN
                r_dir_down <= w_dir_down_nxt;
`endif
            end
            if (w_enter) begin
                r_gate_cnt <= {TEMPO_W{1'b0}};
            end else if (bus.run && (r_gate_cnt < bus.gate_period)) begin
                r_gate_cnt <= r_gate_cnt + TEMPO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_note_ram[i] <= {NOTE_W{1'b0}};
            end
        end else if (bus.cfg_we && (32'(bus.cfg_addr) < 32'(NUM_STEPS))) begin
            r_note_ram[bus.cfg_addr] <= bus.cfg_note;
        end
    end

    seq_tone_gen #(.TONE_W(TONE_W)) u_tone (
        .clk       (clk),
        .rst       (rst),
        .i_en      (bus.run),
        .i_restart (w_enter),
        .i_half    (w_half),
        .o_sq      (w_tone_sq)
    );

    assign bus.snd_out   = r_snd;
    assign bus.step_led  = r_led;
    assign bus.step_idx  = r_step;
    assign bus.step_tick = r_tick;
endmodule

// File: tb/tb_step_sequencer_engine.sv
// Self-checking bench: directed scenarios plus randomized segments, compared
// every cycle against a step/age based reference model.
module tb_step_sequencer_engine;
    localparam int N     = 8;
    localparam int SHIFT = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    step_sequencer_engine_if #(.NUM_STEPS(N)) bus ();

    step_sequencer_engine #(.NUM_STEPS(N), .TONE_SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: current step, run cycles since step entry, tone half-period
    int m_step, m_age, m_half, m_tcount;
    bit m_prev_run, m_down;
    int m_ram [N];
    bit exp_snd, exp_tick;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_half(input int note);
        int h;
        h = 25_000_000 / (250 + 50 * note);
        h = h >> SHIFT;
        if (h < 1) h = 1;
        return h;
    endfunction

    task automatic model_reset();
        m_step = 0; m_age = 0; m_half = 1; m_tcount = 0;
        m_prev_run = 1'b0; m_down = 1'b0;
        exp_snd = 1'b0; exp_tick = 1'b0;
        for (int i = 0; i < N; i++) m_ram[i] = 0;
    endtask

    task automatic model_edge();
        bit adv;
        int a;
        if (rst) begin
            model_reset();
            return;
        end
        if (!bus.run) begin
            exp_snd = 1'b0; exp_tick = 1'b0; m_tcount = 0; m_prev_run = 1'b0;
        end else begin
            adv = (m_tcount == int'(bus.tempo_period));
            a = m_age;
            exp_snd = m_prev_run && bus.step_mask[m_step] && (a < int'(bus.gate_period))
                      && (((a / m_half) % 2) == 0);
            exp_tick = adv;
            if (adv) begin
                m_tcount = 0;
                case (int'(bus.dir_mode))
                    1: m_step = (m_step == 0) ? N - 1 : m_step - 1;
`ifdef SEQ_PINGPONG_EN
                    2: begin
                        if (m_step == N - 1) m_down = 1'b1;
                        else if (m_step == 0) m_down = 1'b0;
                        m_step = m_down ? m_step - 1 : m_step + 1;
                    end
`endif
                    default: m_step = (m_step + 1) % N;
                endcase
                m_half = ref_half(m_ram[m_step]);
                m_age = 0;
            end else begin
                m_tcount++;
                if (!m_prev_run) begin
                    m_half = ref_half(m_ram[m_step]);
                    m_age = 0;
                end else begin
                    m_age++;
                end
            end
            m_prev_run = 1'b1;
        end
        if (bus.cfg_we && int'(bus.cfg_addr) < N) m_ram[bus.cfg_addr] = int'(bus.cfg_note);
    endtask

    task automatic check_outputs();
        logic [31:0] led_exp;
        led_exp = 32'd1 << m_step;
        check_val("step_idx", 32'(bus.step_idx), 32'(m_step));
        check_val("step_led", 32'(bus.step_led), led_exp);
        check_val("step_tick", 32'(bus.step_tick), 32'(exp_tick));
        check_val("snd_out", 32'(bus.snd_out), 32'(exp_snd));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pause();
        bus.run = 1'b0;
        bus.cfg_we = 1'b0;
        run_cycles(2);
    endtask

    task automatic write_note(input int addr, input int note);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_note = 4'(note);
        cycle();
        bus.cfg_we = 1'b0;
    endtask

    // Asserts rst between edges and checks the outputs before the next clock
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until(input int s, input int age, input int limit, input string tag);
        int k;
        k = 0;
        while (!(m_step == s && m_age == age) && k < limit) begin
            cycle();
            k++;
        end
        check_val(tag, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int len;
        bus.run = 1'b0; bus.dir_mode = 2'd0;
        bus.tempo_period = 28'd0; bus.gate_period = 28'd0;
        bus.step_mask = 8'hFF; bus.cfg_we = 1'b0;
        bus.cfg_addr = 3'd0; bus.cfg_note = 4'd0;
        rst = 1'b0;
        model_reset();
        #3 rst = 1'b1;
        #1 check_outputs();
        run_cycles(3);
        rst = 1'b0;

        bus.tempo_period = 28'd9; bus.gate_period = 28'd5; bus.run = 1'b1;
        run_cycles(85);

        pause();
        bus.dir_mode = 2'd1; bus.run = 1'b1;
        run_cycles(45);

        pulse_reset();
        bus.dir_mode = 2'd2; bus.run = 1'b1;
        run_cycles(165);

        pause();
        bus.dir_mode = 2'd0;
        write_note(3, 15);
        write_note(4, 0);
        bus.tempo_period = 28'd199; bus.gate_period = 28'd100; bus.step_mask = 8'hFF;
        bus.run = 1'b1;
        run_cycles(1650);

        bus.step_mask = 8'b1111_0111;
        run_cycles(1650);

        pause();
        bus.gate_period = 28'd0; bus.run = 1'b1;
        run_cycles(450);

        pause();
        bus.gate_period = 28'd100; bus.step_mask = 8'hFF; bus.run = 1'b1;
        run_until(5, 60, 2000, "reach_step5");
        bus.run = 1'b0;
        run_cycles(50);
        bus.run = 1'b1;
        run_cycles(300);

        write_note(6, 15);
        write_note(0, 9);
        run_until(6, 30, 2000, "reach_step6");
        pulse_reset();
        bus.run = 1'b1;
        run_cycles(260);

        for (int seg = 0; seg < 40; seg++) begin
            pause();
            bus.tempo_period = 28'($urandom_range(0, 30));
            bus.gate_period  = 28'($urandom_range(0, 40));
            bus.dir_mode     = 2'($urandom_range(0, 3));
            bus.step_mask    = 8'($urandom);
            bus.run = 1'b1;
            len = $urandom_range(20, 150);
            for (int c = 0; c < len; c++) begin
                bus.cfg_we   = ($urandom_range(0, 3) == 0);
                bus.cfg_addr = 3'($urandom);
                bus.cfg_note = 4'($urandom);
                if ($urandom_range(0, 15) == 0) bus.step_mask = 8'($urandom);
                cycle();
            end
            if (seg % 10 == 9) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
